mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_arb_counter.sv | 22 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Default bus widths; the command bundle below is sized by these.
  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  // Access size used for every instruction fetch.
  localparam logic [2:0] FUNC3_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // Everything the arbiter holds stable on the memory side while busy.
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [2:0]            func3;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: request/command out, ready/data back.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [2:0]        m_func3;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;

  // The arbiter drives the request side.
  modport master (
    output m_req, m_we, m_addr, m_wdata, m_func3,
    input  m_ready, m_rdata
  );

  // The memory answers with ready and read data.
  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_func3,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/mem_arb_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module mem_arb_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count up on enable, stick at MAX, clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && (count != W'(MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and
// the MEM stage: data has priority, fetch is protected by a starvation
// limit, and a stuck memory access is aborted after a timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_func3,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              err,
  mem_port_arbiter_if.master mem
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_e    state_q, state_d;
  mem_cmd_t      cmd_q;
  logic          m_req_q;
  logic          grant_i, grant_d, finish, timed_out;
  logic          starve_full;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  assign starve_full = (starve_cnt == SW'(STARVE_LIM));

  // Consecutive data grants taken while a fetch was waiting.
  mem_arb_counter #(.MAX(STARVE_LIM), .W(SW)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q == IDLE) && (grant_i || !i_req)),
    .en    (grant_d && i_req),
    .count (starve_cnt)
  );

  // Cycles spent in the current busy state; zero again whenever idle.
  mem_arb_counter #(.MAX(TIMEOUT - 1), .W(TW)) u_tmo_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == IDLE),
    .en    (state_q != IDLE),
    .count (tmo_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Arbitration in IDLE, completion or timeout detection while busy.
  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !(i_req && starve_full)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem.m_ready) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's command, then return data and pulse done/err.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_req_q <= 1'b0;
      cmd_q   <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      if (grant_i) begin
        m_req_q <= 1'b1;
        cmd_q   <= '{we: 1'b0, addr: i_addr, wdata: '0, func3: FUNC3_WORD};
      end else if (grant_d) begin
        m_req_q <= 1'b1;
        cmd_q   <= '{we: d_we, addr: d_addr, wdata: d_wdata, func3: d_func3};
      end
      if (finish) begin
        m_req_q <= 1'b0;
        err     <= timed_out;
        if (state_q == BUSY_I) begin
          i_done  <= 1'b1;
          i_rdata <= timed_out ? '0 : mem.m_rdata;
        end else begin
          d_done  <= 1'b1;
          d_rdata <= timed_out ? '0 : mem.m_rdata;
        end
      end
    end
  end

  assign mem.m_req   = m_req_q;
  assign mem.m_we    = cmd_q.we;
  assign mem.m_addr  = cmd_q.addr;
  assign mem.m_wdata = cmd_q.wdata;
  assign mem.m_func3 = cmd_q.func3;

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level
// reference model of memory contents and arbitration fairness.
module tb_mem_port_arbiter;

  localparam int STARVE_LIM = 4;
  localparam int TIMEOUT    = 15;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [8:0]  i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_func3;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) mem ();

  mem_port_arbiter #(
    .ADDR_W(9), .DATA_W(32), .STARVE_LIM(STARVE_LIM), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .i_stall (i_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_func3 (d_func3),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_stall (d_stall),
    .err     (err),
    .mem     (mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers after a configurable number of wait states.
  logic [31:0] mem_array [0:127];
  logic [31:0] ref_mem   [0:127];
  int  mem_wait    = 0;
  bit  mem_mute    = 0;
  bit  mem_rand    = 0;
  bit  force_ready = 0;
  int  mcnt        = 0;
  int  mwait_cur   = 0;
  bit  mseen       = 0;

  initial begin
    mem.m_ready = 1'b0;
    mem.m_rdata = '0;
  end

  always @(posedge clk) begin
    #2;
    if (mem.m_req) begin
      if (!mseen) begin
        mseen     = 1;
        mcnt      = 0;
        mwait_cur = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
      end
      if (!mem_mute && mcnt == mwait_cur) begin
        mem.m_ready = 1'b1;
        mem.m_rdata = mem_array[mem.m_addr[8:2]];
        if (mem.m_we) mem_array[mem.m_addr[8:2]] = mem.m_wdata;
      end else begin
        mem.m_ready = force_ready;
        mem.m_rdata = 32'h0BADF00D;
      end
      mcnt++;
    end else begin
      mseen       = 0;
      mem.m_ready = force_ready;
      mem.m_rdata = 32'hFFFF_FFFF;
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    int          wait_st;
    bit          mute;
    int          exp_lat;
    logic [2:0]  exp_func3;
    logic [31:0] exp_rdata;
    bit          chk_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic initMem();
    for (int k = 0; k < 128; k++) begin
      mem_array[k] = 32'hA5A50000 + 32'(k);
      ref_mem[k]   = 32'hA5A50000 + 32'(k);
    end
    mem_array[4] = 32'h00500093;
    ref_mem[4]   = 32'h00500093;
  endtask

  task automatic applyStimulus(input vec_t v);
    mem_wait = v.wait_st;
    mem_mute = v.mute;
    if (v.is_d) begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
      d_func3 = v.func3;
    end else begin
      i_req  = 1'b1;
      i_addr = v.addr;
    end
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int  lat;
    bit  got;
    bit  other;
    lat   = 0;
    got   = 0;
    other = 0;
    applyStimulus(v);
    #1;
    checkOutput({tag, ".stall_req"}, v.is_d ? d_stall : i_stall, 1);
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      if (c == 1) begin
        checkOutput({tag, ".m_req"}, mem.m_req, 1);
        checkOutput({tag, ".m_we"}, mem.m_we, v.we);
        checkOutput({tag, ".m_addr"}, mem.m_addr, v.addr);
        checkOutput({tag, ".m_func3"}, mem.m_func3, v.exp_func3);
        if (v.is_d) checkOutput({tag, ".m_wdata"}, mem.m_wdata, v.wdata);
      end
      if (v.is_d ? i_done : d_done) other = 1;
      if (v.is_d ? d_done : i_done) begin
        got = 1;
        lat = c;
        checkOutput({tag, ".err"}, err, v.exp_err);
        checkOutput({tag, ".m_req_at_done"}, mem.m_req, 0);
        checkOutput({tag, ".stall_done"}, v.is_d ? d_stall : i_stall, 0);
        if (v.chk_rdata) checkOutput({tag, ".rdata"}, v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    checkOutput({tag, ".latency"}, lat, v.exp_lat);
    checkOutput({tag, ".other_done"}, other, 0);
    tick();
    mem_mute = 0;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    d_func3 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Randomized run state: one outstanding transaction per requester.
  bit          i_pend, d_pend, d_cur_we;
  logic [8:0]  i_cur, d_cur;
  logic [31:0] d_cur_wd;
  int          i_wait_d, i_age, max_age, n_done;

  initial begin
    vecs[0] = '{is_d:0, we:0, addr:9'h010, wdata:32'h0, func3:3'b000, wait_st:0, mute:0,
                exp_lat:2, exp_func3:3'b010, exp_rdata:32'h00500093, chk_rdata:1, exp_err:0};
    vecs[1] = '{is_d:1, we:1, addr:9'h020, wdata:32'hDEADBEEF, func3:3'b010, wait_st:2, mute:0,
                exp_lat:4, exp_func3:3'b010, exp_rdata:32'h0, chk_rdata:0, exp_err:0};
    vecs[2] = '{is_d:1, we:0, addr:9'h020, wdata:32'h0, func3:3'b010, wait_st:2, mute:0,
                exp_lat:4, exp_func3:3'b010, exp_rdata:32'hDEADBEEF, chk_rdata:1, exp_err:0};
    vecs[3] = '{is_d:1, we:0, addr:9'h030, wdata:32'h0, func3:3'b100, wait_st:1, mute:0,
                exp_lat:3, exp_func3:3'b100, exp_rdata:32'hA5A5000C, chk_rdata:1, exp_err:0};
    vecs[4] = '{is_d:1, we:0, addr:9'h040, wdata:32'h0, func3:3'b010, wait_st:0, mute:1,
                exp_lat:TIMEOUT + 1, exp_func3:3'b010, exp_rdata:32'h0, chk_rdata:1, exp_err:1};
    vecs[5] = '{is_d:0, we:0, addr:9'h044, wdata:32'h0, func3:3'b000, wait_st:0, mute:0,
                exp_lat:2, exp_func3:3'b010, exp_rdata:32'hA5A50011, chk_rdata:1, exp_err:0};
    vecs[6] = '{is_d:1, we:1, addr:9'h05C, wdata:32'h000000AB, func3:3'b000, wait_st:3, mute:0,
                exp_lat:5, exp_func3:3'b000, exp_rdata:32'h0, chk_rdata:0, exp_err:0};

    initMem();

    // Reset values, with both requests held so the stalls are visible.
    reset   = 1'b1;
    i_req   = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    d_func3 = '0;
    tick();
    tick();
    checkOutput("rst.m_req", mem.m_req, 0);
    checkOutput("rst.m_we", mem.m_we, 0);
    checkOutput("rst.m_addr", mem.m_addr, 0);
    checkOutput("rst.m_wdata", mem.m_wdata, 0);
    checkOutput("rst.m_func3", mem.m_func3, 0);
    checkOutput("rst.i_done", i_done, 0);
    checkOutput("rst.d_done", d_done, 0);
    checkOutput("rst.err", err, 0);
    checkOutput("rst.i_rdata", i_rdata, 0);
    checkOutput("rst.d_rdata", d_rdata, 0);
    checkOutput("rst.i_stall", i_stall, 1);
    checkOutput("rst.d_stall", d_stall, 1);
    doReset();

    // Directed single transactions from the vector table.
    for (int n = 0; n < 7; n++) runVector(vecs[n], $sformatf("vec%0d", n));

    // Both requesters held for 12 transactions: D,D,D,D,I repeating.
    begin
      int n;
      int stall_bad;
      n         = 0;
      stall_bad = 0;
      doReset();
      mem_wait = 0;
      i_req    = 1'b1;
      i_addr   = 9'h010;
      d_req    = 1'b1;
      d_we     = 1'b0;
      d_addr   = 9'h024;
      d_func3  = 3'b010;
      for (int c = 0; c < 200 && n < 12; c++) begin
        tick();
        if (i_req && (i_stall !== ~i_done)) stall_bad++;
        if (i_done || d_done) begin
          checkOutput($sformatf("starve.grant%0d_is_i", n), i_done, (n % 5 == 4) ? 1 : 0);
          n++;
          if (n == 12) begin
            i_req = 1'b0;
            d_req = 1'b0;
          end
        end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      checkOutput("starve.count", n, 12);
      checkOutput("starve.i_stall", stall_bad, 0);
      tick();
    end

    // Fetch drops its request while busy; data arrives in the same cycle.
    begin
      i_req = 1'b1;
      i_addr = 9'h010;
      tick();
      checkOutput("drop.m_req_i", mem.m_req, 1);
      i_req  = 1'b0;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 9'h030;
      tick();
      checkOutput("drop.i_done", i_done, 1);
      checkOutput("drop.i_rdata", i_rdata, 32'h00500093);
      checkOutput("drop.d_done_early", d_done, 0);
      checkOutput("drop.m_req_gap", mem.m_req, 0);
      tick();
      checkOutput("drop.m_req_d", mem.m_req, 1);
      checkOutput("drop.m_addr_d", mem.m_addr, 9'h030);
      tick();
      checkOutput("drop.d_done", d_done, 1);
      checkOutput("drop.d_rdata", d_rdata, 32'hA5A5000C);
      d_req = 1'b0;
      tick();
    end

    // Reset while a store is stuck in BUSY_D; late ready is ignored.
    begin
      int late;
      late     = 0;
      mem_mute = 1;
      d_req    = 1'b1;
      d_we     = 1'b1;
      d_addr   = 9'h048;
      d_wdata  = 32'h12345678;
      d_func3  = 3'b010;
      tick();
      checkOutput("rstmid.m_req_before", mem.m_req, 1);
      reset = 1'b1;
      d_req = 1'b0;
      tick();
      reset = 1'b0;
      checkOutput("rstmid.m_req", mem.m_req, 0);
      checkOutput("rstmid.m_we", mem.m_we, 0);
      checkOutput("rstmid.m_addr", mem.m_addr, 0);
      checkOutput("rstmid.m_wdata", mem.m_wdata, 0);
      checkOutput("rstmid.d_done", d_done, 0);
      checkOutput("rstmid.d_rdata", d_rdata, 0);
      checkOutput("rstmid.i_rdata", i_rdata, 0);
      force_ready = 1;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (d_done || i_done || err || mem.m_req) late++;
      end
      force_ready = 0;
      mem_mute    = 0;
      checkOutput("rstmid.late_ready", late, 0);
    end

    // Randomized traffic against the transaction-level reference model.
    doReset();
    initMem();
    mem_rand = 1;
    i_pend   = 0;
    d_pend   = 0;
    i_wait_d = 0;
    i_age    = 0;
    max_age  = 0;
    n_done   = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      checkOutput("rand.one_done", i_done & d_done, 0);
      checkOutput("rand.done_mreq", (i_done | d_done) & mem.m_req, 0);
      checkOutput("rand.err", err, 0);
      checkOutput("rand.i_stall", i_stall, i_req & ~i_done);
      checkOutput("rand.d_stall", d_stall, d_req & ~d_done);
      if (i_done) begin
        checkOutput("rand.i_owner", i_pend, 1);
        if (i_pend) checkOutput("rand.i_rdata", i_rdata, ref_mem[i_cur[8:2]]);
        checkOutput("rand.starve_bound", (i_wait_d <= STARVE_LIM + 1) ? 1 : 0, 1);
        i_pend = 0;
        n_done++;
      end
      if (d_done) begin
        checkOutput("rand.d_owner", d_pend, 1);
        if (d_pend) begin
          if (d_cur_we) ref_mem[d_cur[8:2]] = d_cur_wd;
          else          checkOutput("rand.d_rdata", d_rdata, ref_mem[d_cur[8:2]]);
        end
        if (i_pend) i_wait_d++;
        d_pend = 0;
        n_done++;
      end
      if (i_pend) begin
        i_age++;
        if (i_age > max_age) max_age = i_age;
      end
      if (!i_pend && $urandom_range(0, 2) != 0) begin
        i_pend   = 1;
        i_cur    = 9'($urandom_range(0, 15) * 4);
        i_wait_d = 0;
        i_age    = 0;
      end
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend   = 1;
        d_cur    = 9'($urandom_range(0, 15) * 4);
        d_cur_we = 1'($urandom_range(0, 1));
        d_cur_wd = $urandom;
      end
      i_req   = i_pend;
      i_addr  = i_cur;
      d_req   = d_pend;
      d_we    = d_cur_we;
      d_addr  = d_cur;
      d_wdata = d_cur_wd;
      d_func3 = 3'b010;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    checkOutput("rand.fetch_wait_bounded", (max_age <= 60) ? 1 : 0, 1);
    checkOutput("rand.progress", (n_done > 100) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung handshake.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
